// File: rtl/mpeg_bitwin_reader.sv
// MPEG bitstream window reader.
// Holds an MSB-aligned window of WIDTH bits and hands it to the VLC/header parsers.
// Parsers discard 0..WIDTH bits per flush, and the window refills from a byte stream.
// After the final stream byte, the window is padded with zero bytes so parsing can
// run past the end of the stream.
module mpeg_bitwin_reader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH) + 1,
  parameter int unsigned POSW  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             byte_last,
  output logic             byte_ready,
  input  logic             flush_req,
  input  logic [CW-1:0]    flush_n,
  output logic             flush_ready,
  output logic [WIDTH-1:0] win,
  output logic [CW-1:0]    incnt,
  output logic             win_valid,
  output logic             done,
  output logic             flush_err,
  output logic             eos,
  output logic [POSW-1:0]  bit_pos
);

  typedef enum logic [0:0] {StFill, StReady} state_e;

  localparam logic [CW-1:0] Byte8   = CW'(8);
  localparam logic [CW-1:0] WidthM8 = CW'(WIDTH - 8);
  localparam logic [CW-1:0] WidthC  = CW'(WIDTH);

  state_e state;

  // Next-state helpers
  logic [CW-1:0]    fill_shift;
  logic [CW-1:0]    fill_incnt;
  logic [WIDTH-1:0] merge_byte;
  logic             fill_adv;
  logic             flush_bad;
  logic [CW-1:0]    flush_incnt;
  logic [WIDTH-1:0] flush_win;
  logic [POSW-1:0]  flush_pos;

  // Handshake and status outputs depend only on state
  always_comb begin
    byte_ready  = (state == StFill) && !eos;
    flush_ready = (state == StReady);
    win_valid   = (state == StReady);
  end

  // Merge and flush arithmetic for the current window
  always_comb begin
    // While in FILL, incnt <= WIDTH-8, so this shift amount cannot go negative.
    fill_shift  = WidthM8 - incnt;
    merge_byte  = {{(WIDTH - 8){1'b0}}, byte_data} << fill_shift;
    fill_incnt  = incnt + Byte8;
    // After end of stream, a zero byte is merged every cycle without a handshake.
    fill_adv    = eos || byte_valid;
    flush_bad   = (flush_n > incnt) || (flush_n > WidthC);
    flush_incnt = incnt - flush_n;
    // A shift by WIDTH clears the window.
    flush_win   = win << flush_n;
    flush_pos   = bit_pos + {{(POSW - CW){1'b0}}, flush_n};
  end

  // Window, counters and the FILL/READY state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StFill;
      win       <= '0;
      incnt     <= '0;
      bit_pos   <= '0;
      eos       <= 1'b0;
      done      <= 1'b0;
      flush_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      flush_err <= 1'b0;
      case (state)
        StFill: begin
          if (fill_adv) begin
            incnt <= fill_incnt;
            if (!eos) begin
              win <= win | merge_byte;
              if (byte_last) begin
                eos <= 1'b1;
              end
            end
            if (fill_incnt > WidthM8) begin
              state <= StReady;
              done  <= 1'b1;
            end
          end
        end
        StReady: begin
          if (flush_req) begin
            if (flush_bad) begin
              flush_err <= 1'b1;
            end else if (flush_n == '0) begin
              done <= 1'b1;
            end else begin
              win     <= flush_win;
              incnt   <= flush_incnt;
              bit_pos <= flush_pos;
              if (flush_incnt <= WidthM8) begin
                state <= StFill;
              end else begin
                done <= 1'b1;
              end
            end
          end
        end
        default: state <= StFill;
      endcase
    end
  end

endmodule
